ongoru_guncelleme_denetleyici: RTL and testbench
================================================

ONGORU_GUNCELLEME_DENETLEYICI -- requirements
Module: ongoru_guncelleme_denetleyici

Interface
REQ-001 SHALL have parameter KUYRUK_DERINLIK, default 4, meaning number of buffered updates; power of two, minimum 2.
REQ-002 SHALL have parameter BUYRUK_BIT, default 32, meaning instruction and address width.
REQ-003 SHALL have port clk_g  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_g  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port i_gecerli  input  1  execute stage presents a resolved branch or jump update.
REQ-006 SHALL have port o_hazir  output  1  controller accepts the update this cycle.
REQ-007 SHALL have ports i_buyruk / i_buyruk_adresi / i_atlanan_adres  input  BUYRUK_BIT each  resolved instruction, its PC, its actual target.
REQ-008 SHALL have ports i_atladi / i_ongoru_yanlis  input  1 each  actual taken outcome; prediction was wrong.
REQ-009 SHALL have port i_ongoru_mesgul  input  1  predictor performs a fetch-side lookup this cycle.
REQ-010 SHALL have port i_temizle  input  1  pipeline flush; discard all buffered updates.
REQ-011 SHALL have outputs o_guncelle_gecerli_g (1), o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres (BUYRUK_BIT each), o_buyruk_atladi, o_ongoru_yanlis (1 each)  driving the predictor update port.
REQ-012 SHALL have output o_bos  1  queue empty and no update in flight.

Function
REQ-013 SHALL buffer updates in a KUYRUK_DERINLIK-entry in-order FIFO; enqueue when i_gecerli && o_hazir.
REQ-014 o_hazir SHALL be 1 only when count < KUYRUK_DERINLIK and state is not YANLIS; derived from registered state, never from same-cycle dequeue.
REQ-015 SHALL use states BOSTA (empty), BOSALT (non-empty), YANLIS (a mispredicted entry is buffered).
REQ-016 Transitions: BOSTA->BOSALT on enqueue of correct prediction; any state->YANLIS on enqueue with i_ongoru_yanlis=1; YANLIS->BOSTA when the mispredicted entry is issued (it is always the youngest); BOSALT->BOSTA when last entry issued with no enqueue.
REQ-017 SHALL issue at most one update per cycle; outputs registered; entry enqueued in cycle N issues no earlier than cycle N+1; o_guncelle_gecerli_g is a one-cycle pulse per entry.
REQ-018 SHALL withhold issue while i_ongoru_mesgul=1, except when count == KUYRUK_DERINLIK or state is YANLIS, where issue proceeds regardless.
REQ-019 Issued entry fields SHALL equal enqueued fields bit-exact; issue order SHALL equal enqueue order.
REQ-020 Pointers SHALL be log2(KUYRUK_DERINLIK) bits and wrap modulo depth; count SHALL be log2(KUYRUK_DERINLIK)+1 bits.
REQ-021 Simultaneous enqueue and issue SHALL leave count unchanged.
REQ-022 i_temizle SHALL take priority over enqueue and issue: next cycle count=0, pointers=0, state BOSTA, o_guncelle_gecerli_g=0; same-cycle enqueue is dropped.
REQ-023 With o_hazir=0, i_gecerli SHALL be ignored (upstream holds the update).

Reset
REQ-024 On rst_g=0, immediately: state BOSTA, count/pointers 0, o_guncelle_gecerli_g=0, all data outputs 0, o_hazir=0 while asserted, o_bos=1.
REQ-025 Reset deassertion mid-operation SHALL yield empty queue; o_hazir=1 on the first clock edge after release.

Configuration
REQ-026 Macro GUNCELLEME_SAYAC_EN: when defined, SHALL add outputs o_guncelleme_sayisi and o_yanlis_sayisi (32 bits each), incremented per issued update and per issued mispredicted update, wrapping at 2^32, cleared by reset only; when undefined, ports and counters SHALL not exist.

Structure
REQ-027 Opcode constants (JAL, JALR, BRANCH), BUYRUK_BIT and state encodings SHALL live in the shared constants package/header.
REQ-028 SHALL instantiate one sub-module, guncelleme_fifo (storage, pointers, count); FSM and arbitration remain in the top.

Verification
REQ-029 Reset, enqueue 3 correct updates (PC 0x100, 0x104, 0x108), i_ongoru_mesgul=0 -> three consecutive pulses from cycle 1 after first enqueue, PCs in order.
REQ-030 i_ongoru_mesgul=1 held, enqueue 4 updates -> no issue until count=4, then o_hazir=0 and entry PC 0x100 issues next cycle.
REQ-031 Enqueue PC 0x200 with i_ongoru_yanlis=1 after 2 entries -> o_hazir=0 until 0x200 issued with o_ongoru_yanlis=1, then state BOSTA, o_hazir=1.
REQ-032 i_temizle with 3 entries and simultaneous i_gecerli -> next cycle o_bos=1, no further pulses, dropped entry never issued.
REQ-033 Simultaneous enqueue and issue at count=2 for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-034 With GUNCELLEME_SAYAC_EN, 5 updates incl. 2 mispredicts -> o_guncelleme_sayisi=5, o_yanlis_sayisi=2; rst_g=0 mid-stream -> both 0 and o_guncelle_gecerli_g=0 without a clock edge.

Source files
------------

// File: rtl/ongoru_guncelleme_denetleyici_pkg.sv
// Shared constants for the branch predictor update controller:
// RISC-V control-flow opcodes, default instruction width and FSM encodings.
package ongoru_guncelleme_denetleyici_pkg;

  localparam int BUYRUK_BIT = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Controller states: empty, draining correct updates, mispredict buffered.
  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] BOSALT = 2'd1;
  localparam logic [1:0] YANLIS = 2'd2;

  // Width of one packed queue entry: {yanlis, atladi, buyruk, adres, hedef}.
  function automatic int giris_genislik(input int w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/ongoru_guncelleme_denetleyici_fifo.sv
// guncelleme_fifo: in-order storage for pending predictor updates.
// Pointers wrap modulo DERINLIK; sayac is one bit wider than the pointers.
// The caller only asserts yaz when not full and oku when not empty.
module guncelleme_fifo #(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = 98
) (
  input  logic                      clk_g,
  input  logic                      rst_g,
  input  logic                      temizle,
  input  logic                      yaz,
  input  logic [GENISLIK-1:0]       yaz_veri,
  input  logic                      oku,
  output logic [GENISLIK-1:0]       bas_veri,
  output logic [$clog2(DERINLIK):0] sayac
);
  import ongoru_guncelleme_denetleyici_pkg::*;

  localparam int PW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] bellek [DERINLIK];
  logic [PW-1:0]       yaz_ptr;
  logic [PW-1:0]       oku_ptr;

  // Entry storage; contents need no reset because sayac gates visibility.
  always_ff @(posedge clk_g) begin
    if (yaz) bellek[yaz_ptr] <= yaz_veri;
  end

  // Pointer and occupancy bookkeeping; flush returns everything to zero.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else if (temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
    end else begin
      if (yaz) yaz_ptr <= yaz_ptr + 1'b1;
      if (oku) oku_ptr <= oku_ptr + 1'b1;
      case ({yaz, oku})
        2'b10:   sayac <= sayac + 1'b1;
        2'b01:   sayac <= sayac - 1'b1;
        default: sayac <= sayac;
      endcase
    end
  end

  assign bas_veri = bellek[oku_ptr];

endmodule

// File: rtl/ongoru_guncelleme_denetleyici.sv
// ongoru_guncelleme_denetleyici: buffers resolved branch/jump outcomes from
// execute and replays them into the predictor when it is not busy with a
// fetch lookup. A full queue or a buffered mispredict forces issue.
// Optional feature macro: GUNCELLEME_SAYAC_EN adds update/mispredict counters.
//
// Handshake: an update transfers on a rising edge where i_gecerli && o_hazir;
// o_hazir depends only on registered state, and upstream holds the update
// while o_hazir is low. o_guncelle_gecerli_g is a one-cycle pulse per issued
// entry with no backpressure from the predictor.
module ongoru_guncelleme_denetleyici #(
  parameter int KUYRUK_DERINLIK = 4,
  parameter int BUYRUK_BIT      = ongoru_guncelleme_denetleyici_pkg::BUYRUK_BIT
) (
  input  logic                  clk_g,
  input  logic                  rst_g,
  input  logic                  i_gecerli,
  output logic                  o_hazir,
  input  logic [BUYRUK_BIT-1:0] i_buyruk,
  input  logic [BUYRUK_BIT-1:0] i_buyruk_adresi,
  input  logic [BUYRUK_BIT-1:0] i_atlanan_adres,
  input  logic                  i_atladi,
  input  logic                  i_ongoru_yanlis,
  input  logic                  i_ongoru_mesgul,
  input  logic                  i_temizle,
  output logic                  o_guncelle_gecerli_g,
  output logic [BUYRUK_BIT-1:0] o_eski_buyruk,
  output logic [BUYRUK_BIT-1:0] o_eski_buyruk_adresi,
  output logic [BUYRUK_BIT-1:0] o_atlanan_adres,
  output logic                  o_buyruk_atladi,
  output logic                  o_ongoru_yanlis,
  output logic                  o_bos,
`ifdef GUNCELLEME_SAYAC_EN
  output logic [31:0]           o_guncelleme_sayisi,
  output logic [31:0]           o_yanlis_sayisi,
`endif
  output logic [1:0]            o_durum
);
  import ongoru_guncelleme_denetleyici_pkg::*;

  localparam int GW = giris_genislik(BUYRUK_BIT);
  localparam int CW = $clog2(KUYRUK_DERINLIK) + 1;
  localparam logic [CW-1:0] DOLU = CW'(KUYRUK_DERINLIK);
  localparam logic [CW-1:0] BIR  = CW'(1);

  logic [1:0]    durum;
  logic [1:0]    durum_d;
  logic [CW-1:0] sayac;
  logic [GW-1:0] yaz_veri;
  logic [GW-1:0] bas_veri;
  logic          dolu;
  logic          yukle;
  logic          cikar;

  assign dolu     = (sayac == DOLU);
  assign o_hazir  = rst_g && !dolu && (durum != YANLIS);
  assign yukle    = i_gecerli && o_hazir && !i_temizle;
  // Busy predictor defers issue unless the queue is full or a mispredict waits.
  assign cikar    = !i_temizle && (sayac != '0) &&
                    (!i_ongoru_mesgul || dolu || (durum == YANLIS));
  assign yaz_veri = {i_ongoru_yanlis, i_atladi, i_buyruk, i_buyruk_adresi, i_atlanan_adres};
  assign o_bos    = (sayac == '0) && !o_guncelle_gecerli_g;
  assign o_durum  = durum;

  guncelleme_fifo #(
    .DERINLIK (KUYRUK_DERINLIK),
    .GENISLIK (GW)
  ) u_fifo (
    .clk_g    (clk_g),
    .rst_g    (rst_g),
    .temizle  (i_temizle),
    .yaz      (yukle),
    .yaz_veri (yaz_veri),
    .oku      (cikar),
    .bas_veri (bas_veri),
    .sayac    (sayac)
  );

  // Next state; the mispredicted entry is always the youngest, so it leaves
  // the queue exactly when the last entry issues.
  always_comb begin
    durum_d = durum;
    if (i_temizle) begin
      durum_d = BOSTA;
    end else if (yukle && i_ongoru_yanlis) begin
      durum_d = YANLIS;
    end else begin
      case (durum)
        BOSTA:   if (yukle) durum_d = BOSALT;
        BOSALT:  if (cikar && (sayac == BIR) && !yukle) durum_d = BOSTA;
        YANLIS:  if (cikar && (sayac == BIR)) durum_d = BOSTA;
        default: durum_d = BOSTA;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) durum <= BOSTA;
    else        durum <= durum_d;
  end

  // Registered predictor update port; fields load only when an entry issues.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      o_guncelle_gecerli_g <= 1'b0;
      o_eski_buyruk        <= '0;
      o_eski_buyruk_adresi <= '0;
      o_atlanan_adres      <= '0;
      o_buyruk_atladi      <= 1'b0;
      o_ongoru_yanlis      <= 1'b0;
    end else begin
      o_guncelle_gecerli_g <= cikar;
      if (cikar) begin
        {o_ongoru_yanlis, o_buyruk_atladi, o_eski_buyruk,
         o_eski_buyruk_adresi, o_atlanan_adres} <= bas_veri;
      end
    end
  end

`ifdef GUNCELLEME_SAYAC_EN
  // Free-running issue statistics, wrapping naturally; cleared only by reset.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      o_guncelleme_sayisi <= '0;
      o_yanlis_sayisi     <= '0;
    end else if (cikar) begin
      o_guncelleme_sayisi <= o_guncelleme_sayisi + 32'd1;
      if (bas_veri[GW-1]) o_yanlis_sayisi <= o_yanlis_sayisi + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ongoru_guncelleme_denetleyici.sv
// Bench for ongoru_guncelleme_denetleyici: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
// GUNCELLEME_SAYAC_EN, when defined, also checks the statistics counters.
module tb_ongoru_guncelleme_denetleyici;
  localparam int D = 4;
  localparam int W = 32;
  localparam logic [1:0] S_BOSTA  = 2'd0;
  localparam logic [1:0] S_BOSALT = 2'd1;
  localparam logic [1:0] S_YANLIS = 2'd2;

  logic          clk_g = 1'b0;
  logic          rst_g = 1'b0;
  logic          i_gecerli = 1'b0;
  logic          o_hazir;
  logic [W-1:0]  i_buyruk = '0;
  logic [W-1:0]  i_buyruk_adresi = '0;
  logic [W-1:0]  i_atlanan_adres = '0;
  logic          i_atladi = 1'b0;
  logic          i_ongoru_yanlis = 1'b0;
  logic          i_ongoru_mesgul = 1'b0;
  logic          i_temizle = 1'b0;
  logic          o_guncelle_gecerli_g;
  logic [W-1:0]  o_eski_buyruk;
  logic [W-1:0]  o_eski_buyruk_adresi;
  logic [W-1:0]  o_atlanan_adres;
  logic          o_buyruk_atladi;
  logic          o_ongoru_yanlis;
  logic          o_bos;
  logic [1:0]    o_durum;
`ifdef GUNCELLEME_SAYAC_EN
  logic [31:0]   o_guncelleme_sayisi;
  logic [31:0]   o_yanlis_sayisi;
`endif

  ongoru_guncelleme_denetleyici #(.KUYRUK_DERINLIK(D), .BUYRUK_BIT(W)) dut (
    .clk_g                (clk_g),
    .rst_g                (rst_g),
    .i_gecerli            (i_gecerli),
    .o_hazir              (o_hazir),
    .i_buyruk             (i_buyruk),
    .i_buyruk_adresi      (i_buyruk_adresi),
    .i_atlanan_adres      (i_atlanan_adres),
    .i_atladi             (i_atladi),
    .i_ongoru_yanlis      (i_ongoru_yanlis),
    .i_ongoru_mesgul      (i_ongoru_mesgul),
    .i_temizle            (i_temizle),
    .o_guncelle_gecerli_g (o_guncelle_gecerli_g),
    .o_eski_buyruk        (o_eski_buyruk),
    .o_eski_buyruk_adresi (o_eski_buyruk_adresi),
    .o_atlanan_adres      (o_atlanan_adres),
    .o_buyruk_atladi      (o_buyruk_atladi),
    .o_ongoru_yanlis      (o_ongoru_yanlis),
    .o_bos                (o_bos),
`ifdef GUNCELLEME_SAYAC_EN
    .o_guncelleme_sayisi  (o_guncelleme_sayisi),
    .o_yanlis_sayisi      (o_yanlis_sayisi),
`endif
    .o_durum              (o_durum)
  );

  // Clock / reset
  always #5 clk_g = ~clk_g;

  typedef struct {
    logic [W-1:0] buyruk;
    logic [W-1:0] pc;
    logic [W-1:0] hedef;
    logic         atladi;
    logic         yanlis;
  } ent_t;

  typedef struct {
    logic         g;
    logic         m;
    logic [W-1:0] pc;
    logic         exp_h;
    logic         exp_v;
    logic [W-1:0] exp_pc;
  } vec_t;

  // Scoreboard: entries accepted but not yet issued, oldest first.
  ent_t        exp_q[$];
  int          vec_cnt = 0;
  int          miscmp = 0;
  logic        last_h;
  logic [31:0] mdl_gun = 0;
  logic [31:0] mdl_yan = 0;
  vec_t        tbl[5];

  task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", ad, act, exp, $time);
    end
  endtask

  function automatic ent_t mk_ent(input logic [W-1:0] pc, input logic yanlis);
    ent_t e;
    e.pc     = pc;
    e.buyruk = pc ^ 32'hA5A5_0063;
    e.hedef  = pc + 32'h40;
    e.atladi = pc[3];
    e.yanlis = yanlis;
    return e;
  endfunction

  // One clock cycle: drive inputs, check pre-edge state against the model,
  // advance the model by the acceptance/issue rules, check post-edge outputs.
  task automatic cycle(input logic g, input logic m, input logic t, input ent_t e);
    logic has_y, exp_h, enq, iss, exp_v;
    logic [1:0] exp_s;
    ent_t out;
    has_y = 1'b0;
    foreach (exp_q[k]) if (exp_q[k].yanlis) has_y = 1'b1;
    exp_h = (exp_q.size() < D) && !has_y;
    exp_s = (exp_q.size() == 0) ? S_BOSTA : (has_y ? S_YANLIS : S_BOSALT);
    i_gecerli = g; i_ongoru_mesgul = m; i_temizle = t;
    i_buyruk = e.buyruk; i_buyruk_adresi = e.pc; i_atlanan_adres = e.hedef;
    i_atladi = e.atladi; i_ongoru_yanlis = e.yanlis;
    #1;
    last_h = o_hazir;
    chk("hazir", o_hazir, exp_h);
    chk("durum", o_durum, exp_s);
    enq = g && exp_h && !t;
    iss = !t && (exp_q.size() > 0) && (!m || exp_q.size() == D || has_y);
    exp_v = 1'b0;
    out = e;
    if (t) begin
      exp_q.delete();
    end else begin
      if (iss) begin
        out = exp_q.pop_front();
        exp_v = 1'b1;
        mdl_gun = mdl_gun + 1;
        if (out.yanlis) mdl_yan = mdl_yan + 1;
      end
      if (enq) exp_q.push_back(e);
    end
    @(posedge clk_g); #1;
    chk("gecerli", o_guncelle_gecerli_g, exp_v);
    if (exp_v) begin
      chk("pc", o_eski_buyruk_adresi, out.pc);
      chk("buyruk", o_eski_buyruk, out.buyruk);
      chk("hedef", o_atlanan_adres, out.hedef);
      chk("atladi", o_buyruk_atladi, out.atladi);
      chk("yanlis", o_ongoru_yanlis, out.yanlis);
    end
    chk("bos", o_bos, (exp_q.size() == 0) && !exp_v);
`ifdef GUNCELLEME_SAYAC_EN
    chk("sayac_gun", o_guncelleme_sayisi, mdl_gun);
    chk("sayac_yan", o_yanlis_sayisi, mdl_yan);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, mk_ent(32'h0, 1'b0));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    rst_g = 1'b0;
    i_gecerli = 1'b0; i_temizle = 1'b0; i_ongoru_mesgul = 1'b0;
    #2;
    chk("rst_gecerli", o_guncelle_gecerli_g, 0);
    chk("rst_hazir", o_hazir, 0);
    chk("rst_bos", o_bos, 1);
    chk("rst_durum", o_durum, S_BOSTA);
    chk("rst_pc", o_eski_buyruk_adresi, 0);
    chk("rst_buyruk", o_eski_buyruk, 0);
    chk("rst_hedef", o_atlanan_adres, 0);
    chk("rst_bayrak", {o_buyruk_atladi, o_ongoru_yanlis}, 0);
`ifdef GUNCELLEME_SAYAC_EN
    chk("rst_sayac_gun", o_guncelleme_sayisi, 0);
    chk("rst_sayac_yan", o_yanlis_sayisi, 0);
`endif
    exp_q.delete();
    mdl_gun = 0;
    mdl_yan = 0;
    @(posedge clk_g); #1;
    rst_g = 1'b1;
  endtask

  initial begin
    @(posedge clk_g); #1;
    do_reset();

    // Three back-to-back correct updates with an idle predictor.
    tbl[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b1, 32'h100};
    tbl[2] = '{1'b1, 1'b0, 32'h108, 1'b1, 1'b1, 32'h104};
    tbl[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108};
    tbl[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].g, tbl[i].m, 1'b0, mk_ent(tbl[i].pc, 1'b0));
      chk("tbl_hazir", last_h, tbl[i].exp_h);
      chk("tbl_gecerli", o_guncelle_gecerli_g, tbl[i].exp_v);
      if (tbl[i].exp_v) chk("tbl_pc", o_eski_buyruk_adresi, tbl[i].exp_pc);
    end

    // Busy predictor: nothing issues until the queue fills, then oldest goes.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h100 + 32'(4 * i), 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h500, 1'b0));
    chk("dolu_hazir", last_h, 0);
    chk("dolu_gecerli", o_guncelle_gecerli_g, 1);
    chk("dolu_pc", o_eski_buyruk_adresi, 32'h100);
    idle(6);

    // Mispredict behind two entries drains even while the predictor is busy.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h180, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h184, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h200, 1'b1));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h300, 1'b0));
      chk("yanlis_hazir", last_h, 0);
    end
    chk("yanlis_pc", o_eski_buyruk_adresi, 32'h200);
    chk("yanlis_bayrak", o_ongoru_yanlis, 1);
    chk("yanlis_durum", o_durum, S_BOSTA);
    chk("yanlis_hazir_son", o_hazir, 1);
    idle(2);

    // Flush with three buffered entries and a same-cycle enqueue.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h600 + 32'(4 * i), 1'b0));
    cycle(1'b1, 1'b1, 1'b1, mk_ent(32'h999, 1'b0));
    chk("temizle_bos", o_bos, 1);
    chk("temizle_gecerli", o_guncelle_gecerli_g, 0);
    idle(5);

    // Steady occupancy of two with enqueue and issue every cycle.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h400, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk_ent(32'h404, 1'b0));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, mk_ent(32'h408 + 32'(4 * i), 1'b0));
      chk("sabit_hazir", last_h, 1);
      chk("sabit_durum", o_durum, S_BOSALT);
    end
    idle(4);

    // Five updates including two mispredicts, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, mk_ent(32'h700 + 32'(4 * i), (i == 1) || (i == 3)));
      idle(2);
    end
`ifdef GUNCELLEME_SAYAC_EN
    chk("sayac_bes", o_guncelleme_sayisi, 5);
    chk("sayac_iki", o_yanlis_sayisi, 2);
`endif
    cycle(1'b1, 1'b0, 1'b0, mk_ent(32'h800, 1'b0));
    cycle(1'b0, 1'b0, 1'b0, mk_ent(32'h0, 1'b0));
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0),
            mk_ent($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 7) == 0)));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
